// File: rtl/vector_checker_if.sv
// Bundle between a response checker and whatever feeds it: table load port,
// run control, the DUT response stream and the run results.
interface vector_checker_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 5
);
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [WIDTH-1:0]  exp_data;
    logic [ADDR_W:0]   num_vec;
    logic              start;
    logic              valid;
    logic [WIDTH-1:0]  dut_out;

    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W:0]   vec_idx;
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_idx;

    modport master (
        output exp_we, exp_addr, exp_data, num_vec, start, valid, dut_out,
        input  busy, done, pass, err_count, vec_idx, fail_valid, fail_idx
    );

    modport slave (
        input  exp_we, exp_addr, exp_data, num_vec, start, valid, dut_out,
        output busy, done, pass, err_count, vec_idx, fail_valid, fail_idx
    );
endinterface

// File: rtl/vector_checker.sv
// Response checker: compares the DUT output stream, in order, against a
// preloaded table of expected words and reports mismatch count and first failure.
module vector_checker #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 5
) (
    input logic             clk,
    input logic             reset,
    vector_checker_if.slave bus
);
    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]        state_q;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_d;
    logic [ADDR_W:0]   vec_idx_q;
    logic [ADDR_W:0]   err_q;
    logic              fail_valid_q;
    logic [ADDR_W-1:0] fail_idx_q;
    logic [WIDTH-1:0]  exp_word;
    logic              mismatch;
    logic              last;

    // Requests longer than the table are clamped to a full-table run.
    assign len_d    = (bus.num_vec > DEPTH_W) ? DEPTH_W : bus.num_vec;
    // vec_idx stays below len (<= DEPTH) while running, so the low bits index the table.
    assign exp_word = mem[vec_idx_q[ADDR_W-1:0]];
    assign mismatch = bus.dut_out != exp_word;
    assign last     = vec_idx_q == (len_q - ONE);

    // Table is deliberately not reset so a loaded vector set survives a reset.
    always_ff @(posedge clk) begin
        if (reset && bus.exp_we && state_q != S_RUN)
            mem[bus.exp_addr] <= bus.exp_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            vec_idx_q    <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        len_q        <= len_d;
                        vec_idx_q    <= '0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        fail_idx_q   <= '0;
                        state_q      <= (len_d == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.valid) begin
                        if (mismatch) begin
                            err_q <= err_q + ONE;
                            if (!fail_valid_q) begin
                                fail_valid_q <= 1'b1;
                                fail_idx_q   <= vec_idx_q[ADDR_W-1:0];
                            end
                        end
                        vec_idx_q <= vec_idx_q + ONE;
                        if (last)
                            state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = state_q == S_RUN;
    assign bus.done       = state_q == S_DONE;
    assign bus.pass       = (state_q == S_DONE) && (err_q == '0);
    assign bus.err_count  = err_q;
    assign bus.vec_idx    = vec_idx_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_idx   = fail_idx_q;
endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesizable response checker for the single-cycle processor lab blocks. It holds a table of expected DUT output words and compares each one, in order, against the live DUT output on cycles marked valid. It counts mismatches and reports pass/fail once the programmed number of vectors has been consumed. It is the consuming end of the stimulus/response flow: stimulus vectors drive the DUT, and this block checks what comes back, on-chip or in simulation.

## Interface
- WIDTH, 4, width of the DUT output word being checked
- ADDR_W, 5, index width; table depth is 2**ADDR_W (32)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- exp_we  in  1  write enable for the expected-value table
- exp_addr  in  ADDR_W  table write index
- exp_data  in  WIDTH  expected word to store
- num_vec  in  ADDR_W+1  number of vectors to check; sampled on start
- start  in  1  begin a check run
- valid  in  1  dut_out holds a response to check this cycle
- dut_out  in  WIDTH  DUT response word
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  done and err_count==0
- err_count  out  ADDR_W+1  number of mismatches in the current/last run
- vec_idx  out  ADDR_W+1  index of the next vector to compare
- fail_valid  out  1  at least one mismatch recorded
- fail_idx  out  ADDR_W  index of the first mismatch

## Operation
- Table: 2**ADDR_W x WIDTH register array. Not reset; contents survive reset. Read is combinational at vec_idx.
- Writes (exp_we=1) take effect only in IDLE or DONE. Writes are ignored in RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, latch len = min(num_vec, 2**ADDR_W), clear err_count, vec_idx, fail_valid and fail_idx. Go to DONE if len==0, otherwise go to RUN.
  - RUN: on each cycle with valid=1, compare dut_out to table[vec_idx].
    - On mismatch, increment err_count. If fail_valid=0, set fail_valid=1 and fail_idx=vec_idx.
    - Increment vec_idx.
    - If vec_idx==len-1 at this compare, go to DONE.
    - valid=0 holds all state. start is ignored in RUN.
  - DONE: hold all results. start=1 restarts exactly as from IDLE, re-sampling num_vec.
- err_count cannot overflow: maximum value 2**ADDR_W fits in ADDR_W+1 bits.
- exp_we and start in the same IDLE/DONE cycle: the write completes, and the first compare (no earlier than the next cycle) sees the new data.

## Timing
- Reset (reset=0 at a rising edge): state=IDLE, busy=0, done=0, pass=0, err_count=0, vec_idx=0, fail_valid=0, fail_idx=0. Reset overrides every other input, including in the middle of a run.
- start sampled at edge k: busy=1 after edge k. Compares happen at edge k+1 or later.
- Final compare at edge m: done=1 and busy=0 after edge m. pass, err_count and fail_* are final at that point.
- Minimum run is len+1 edges from start. Each valid=0 cycle adds one edge.
- len==0: done=1 and pass=1 one edge after start.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Test plan
- Load table[0..3]={0x3,0xA,0x5,0xF}, num_vec=4, start, drive matching dut_out with valid=1 every cycle -> done=1 exactly 5 edges after start, pass=1, err_count=0, fail_valid=0, vec_idx=4.
- Same table, drive dut_out=0x4 at index 2 -> err_count=1, fail_valid=1, fail_idx=2, pass=0.
- Mismatches at indices 1 and 3, with valid low for 3 cycles between indices 1 and 2 -> err_count=2, fail_idx=1, done 8 edges after start.
- num_vec=0 -> done=1 and pass=1 one edge after start. num_vec=40 -> exactly 32 compares.
- reset=0 asserted mid-run at vec_idx=2 -> all outputs return to their reset values on the next edge. A fresh run then uses the unchanged table and passes.
- exp_we=1 writing 0x0 to index 1 during RUN -> table unchanged, run still passes. The same write in DONE followed by a rerun -> mismatch at index 1.
